reg_cmd_ctrl: RTL

Command controller directly upstream of the register file. It consumes byte frames from the UART receiver and decodes write and read commands. It drives the register file's Address/WrEn/RdEn/WrData port and forwards read data to the UART transmitter through a valid/busy handshake. It sits between the RX/TX data-sync stages and the register file, in the reference (CLK) domain.

---
 rtl/sys_ctrl_pkg.sv | 24 ++
 rtl/frame_timeout_cnt.sv | 28 ++
 rtl/reg_cmd_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the register-file command controller:
// FSM state encoding, frame opcodes and the default inter-byte timeout.
package sys_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_TX_SEND = 3'd5
    } state_e;

    localparam logic [7:0] WR_CMD_DEF  = 8'hAA;
    localparam logic [7:0] RD_CMD_DEF  = 8'hBB;
    localparam int         TIMEOUT_DEF = 255;

    // States that wait on an external event and are bounded by the frame timer.
    function automatic logic is_timed(input state_e s);
        return (s == ST_WR_ADDR) || (s == ST_WR_DATA) ||
               (s == ST_RD_ADDR) || (s == ST_RD_WAIT);
    endfunction

endpackage

// File: rtl/frame_timeout_cnt.sv
// Saturating 8-bit idle counter; expired stays high while the count sits at TIMEOUT.
module frame_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/reg_cmd_ctrl.sv
// Decodes UART byte frames into register-file write/read strobes and
// forwards read responses to the transmitter.
//
//  state      | meaning
//  -----------+------------------------------------------------
//  IDLE       | waiting for an opcode byte
//  WR_ADDR    | write frame, waiting for address byte
//  WR_DATA    | write frame, waiting for data byte
//  RD_ADDR    | read frame, waiting for address byte
//  RD_WAIT    | RdEn issued, waiting for RdData_Valid
//  TX_SEND    | read byte held, waiting for TX_BUSY to drop
module reg_cmd_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int                  DATAWIDTH = 8,
    parameter int                  ADDR      = 4,
    parameter logic [DATAWIDTH-1:0] WR_CMD   = WR_CMD_DEF,
    parameter logic [DATAWIDTH-1:0] RD_CMD   = RD_CMD_DEF,
    parameter int                  TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DATAWIDTH-1:0] RX_P_DATA,
    input  logic                 RX_D_VLD,
    output logic [ADDR-1:0]      Address,
    output logic                 WrEn,
    output logic                 RdEn,
    output logic [DATAWIDTH-1:0] WrData,
    input  logic [DATAWIDTH-1:0] RdData,
    input  logic                 RdData_Valid,
    output logic [DATAWIDTH-1:0] TX_P_DATA,
    output logic                 TX_D_VLD,
    input  logic                 TX_BUSY,
    output logic                 CMD_ERR
);

    state_e state;
    logic   tmr_clr;
    logic   tmr_en;
    logic   tmr_expired;

    // Every state change coincides with either a received byte or entry into
    // an untimed state, so these two terms are enough to restart the timer.
    assign tmr_en  = is_timed(state);
    assign tmr_clr = RX_D_VLD || !is_timed(state);

    frame_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            Address   <= '0;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            WrData    <= '0;
            TX_P_DATA <= '0;
            TX_D_VLD  <= 1'b0;
            CMD_ERR   <= 1'b0;
        end else begin
            WrEn     <= 1'b0;
            RdEn     <= 1'b0;
            TX_D_VLD <= 1'b0;
            CMD_ERR  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (RX_D_VLD) begin
                        if (RX_P_DATA == WR_CMD) begin
                            state <= ST_WR_ADDR;
                        end else if (RX_P_DATA == RD_CMD) begin
                            state <= ST_RD_ADDR;
                        end else begin
                            CMD_ERR <= 1'b1;
                        end
                    end
                end

                ST_WR_ADDR: begin
                    if (RX_D_VLD) begin
                        Address <= RX_P_DATA[ADDR-1:0];
                        state   <= ST_WR_DATA;
                    end else if (tmr_expired) begin
                        CMD_ERR <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end

                ST_WR_DATA: begin
                    if (RX_D_VLD) begin
                        WrData <= RX_P_DATA;
                        WrEn   <= 1'b1;
                        state  <= ST_IDLE;
                    end else if (tmr_expired) begin
                        CMD_ERR <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end

                ST_RD_ADDR: begin
                    if (RX_D_VLD) begin
                        Address <= RX_P_DATA[ADDR-1:0];
                        RdEn    <= 1'b1;
                        state   <= ST_RD_WAIT;
                    end else if (tmr_expired) begin
                        CMD_ERR <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end

                ST_RD_WAIT: begin
                    if (RX_D_VLD) begin
                        CMD_ERR <= 1'b1;
                    end
                    // The capture edge already counts as a send opportunity, so an
                    // idle transmitter gets the byte without a TX_SEND detour.
                    if (RdData_Valid) begin
                        TX_P_DATA <= RdData;
                        if (!TX_BUSY) begin
                            TX_D_VLD <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            state <= ST_TX_SEND;
                        end
                    end else if (tmr_expired && !RX_D_VLD) begin
                        CMD_ERR <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end

                ST_TX_SEND: begin
                    if (RX_D_VLD) begin
                        CMD_ERR <= 1'b1;
                    end
                    if (!TX_BUSY) begin
                        TX_D_VLD <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
